// File: rtl/tt_um_prampal_count_checker.sv
// tt_um_prampal_count_checker
// Receive-side checker for a 4-bit counter stream. Each strobed sample must be
// the previous sample + 1 (mod 16). After LOCK_COUNT consecutive correct steps
// the checker locks. A wrong step while locked counts as an error.
//
// Build option: define CHECKER_SYNC_EN to pass ui_in[5:0] through a 2-flop
// synchronizer. This adds 2 cycles of input latency.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    synchronous active-low reset
//   ena      tile power indicator (ignored)
//   ui_in    [3:0] observed count, [4] sample strobe, [5] clear errors
//   uo_out   saturating error count
//   uio_in   unused
//   uio_out  [0] locked, [1] sticky error, [2] error pulse, [3] wrap pulse
//   uio_oe   constant 8'h0F
module tt_um_prampal_count_checker #(
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned IN_W  = 6;
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             sticky_q, sticky_d;
  logic             err_pulse_q, err_pulse_d;
  logic             wrap_q, wrap_d;
  logic             locked_q, locked_d;

  logic [IN_W-1:0]  in_s;
  logic [CNT_W-1:0] obs;
  logic [CNT_W-1:0] expect_val;
  logic [CNT_W-1:0] match_inc;
  logic             strobe;
  logic             clr;
  logic             step_ok;
  logic             err_hit;

  // Unused inputs are folded together so they are visibly consumed.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:6]};

`ifdef CHECKER_SYNC_EN
  logic [IN_W-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous pins; cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ui_in[IN_W-1:0];
      sync2_q <= sync1_q;
    end
  end

  assign in_s = sync2_q;
`else
  assign in_s = ui_in[IN_W-1:0];
`endif

  assign obs    = in_s[3:0];
  assign strobe = in_s[4];
  assign clr    = in_s[5];

  // Next-state and output computation.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_d     = match_q;
    err_cnt_d   = err_cnt_q;
    sticky_d    = sticky_q;
    err_pulse_d = 1'b0;
    wrap_d      = 1'b0;
    err_hit     = 1'b0;
    expect_val  = prev_q + CNT_W'(1);
    match_inc   = match_q + CNT_W'(1);
    step_ok     = (obs == expect_val);

    // Clear takes effect before any error in the same cycle is added.
    if (clr) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end

    if (strobe) begin
      prev_d = obs;
      case (state_q)
        IDLE: begin
          match_d = '0;
          state_d = TRACK;
        end
        TRACK: begin
          if (step_ok) begin
            match_d = match_inc;
            wrap_d  = (prev_q == '1);
            if (match_inc == LOCK_TGT) begin
              state_d = LOCKED;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            wrap_d = (prev_q == '1);
          end else begin
            err_hit = 1'b1;
            match_d = '0;
            state_d = TRACK;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (err_hit) begin
      sticky_d    = 1'b1;
      err_pulse_d = 1'b1;
      if (err_cnt_d != ERR_MAX) begin
        err_cnt_d = err_cnt_d + ERR_W'(1);
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      match_q     <= '0;
      err_cnt_q   <= '0;
      sticky_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      err_cnt_q   <= err_cnt_d;
      sticky_q    <= sticky_d;
      err_pulse_q <= err_pulse_d;
      wrap_q      <= wrap_d;
      locked_q    <= locked_d;
    end
  end

  assign uo_out  = err_cnt_q;
  assign uio_out = {4'b0000, wrap_q, err_pulse_q, sticky_q, locked_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_prampal_count_checker.sv
// Testbench for tt_um_prampal_count_checker: directed stimulus pushes expected
// outputs into a queue tagged with the clock edge they belong to; a monitor on
// the falling edge pops and compares.
module tb_tt_um_prampal_count_checker;

`ifdef CHECKER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_prampal_count_checker dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         tgt;
    logic [7:0] uo;
    logic [7:0] uio;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every expectation whose edge has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].tgt <= edge_cnt) begin
        e = exp_q.pop_front();
        if (e.tgt != edge_cnt) begin
          n_checks++;
          n_err++;
          $display("FAIL %s: missed slot, edge %0d expected at %0d", e.nm, edge_cnt, e.tgt);
        end else begin
          check8({e.nm, ".uo_out"}, uo_out, e.uo);
          check8({e.nm, ".uio_out"}, uio_out, e.uio);
          check8({e.nm, ".uio_oe"}, uio_oe, 8'h0F);
        end
      end
    end
  end

  // One clock of stimulus; optionally queue the expected response.
  task automatic cyc(input logic stb, input logic [3:0] v, input logic clr,
                     input logic chk, input logic [7:0] euo, input logic [7:0] euio,
                     input string nm);
    exp_t e;
    ui_in = {2'b00, clr, stb, v};
    if (chk) begin
      e = '{edge_cnt + 1 + LAT, euo, euio, nm};
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic samp(input logic [3:0] v, input logic [7:0] euo, input logic [7:0] euio,
                      input string nm);
    cyc(1'b1, v, 1'b0, 1'b1, euo, euio, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'(i), 1'b0, 1'b0, 8'h00, 8'h00, "idle");
  endtask

  // Reset takes effect on the next edge regardless of synchronizer depth.
  task automatic do_reset(input string nm);
    exp_t e;
    rst_n = 1'b0;
    ui_in = 8'h00;
    e = '{edge_cnt + 1, 8'h00, 8'h00, nm};
    exp_q.push_back(e);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p;
    logic [3:0] v;
    logic [3:0] nv;
    logic [7:0] ecnt;
    logic [7:0] euio;

    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    @(negedge clk);
    do_reset("reset");
    idle(1);

    // Acquire lock on the 5th sample.
    samp(4'd0, 8'h00, 8'h00, "acq0");
    samp(4'd1, 8'h00, 8'h00, "acq1");
    samp(4'd2, 8'h00, 8'h00, "acq2");
    samp(4'd3, 8'h00, 8'h00, "acq3");
    samp(4'd4, 8'h00, 8'h01, "acq4_lock");

    // Locked mismatch, then relock from the new seed.
    samp(4'd5,  8'h00, 8'h01, "lk5");
    samp(4'd6,  8'h00, 8'h01, "lk6");
    samp(4'd9,  8'h01, 8'h06, "err9");
    samp(4'd10, 8'h01, 8'h02, "rt10");
    samp(4'd11, 8'h01, 8'h02, "rt11");
    samp(4'd12, 8'h01, 8'h02, "rt12");
    samp(4'd13, 8'h01, 8'h03, "relock13");

    // Wrap through 15 -> 0.
    samp(4'd14, 8'h01, 8'h03, "w14");
    samp(4'd15, 8'h01, 8'h03, "w15");
    samp(4'd0,  8'h01, 8'h0B, "wrap0");
    samp(4'd1,  8'h01, 8'h03, "w1");

    // Mismatch with clear in the same cycle, then clear alone.
    cyc(1'b1, 4'd5, 1'b1, 1'b1, 8'h01, 8'h06, "err_clr");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 8'h00, "clr_only");

    // Strobe low with changing data: nothing moves (tracking, prev = 5).
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'(i * 3), 1'b0, 1'b1, 8'h00, 8'h00, "nostb_trk");
    samp(4'd6, 8'h00, 8'h00, "t6");
    samp(4'd7, 8'h00, 8'h00, "t7");
    samp(4'd8, 8'h00, 8'h00, "t8");
    samp(4'd9, 8'h00, 8'h01, "lock9");
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'(i + 2), 1'b0, 1'b1, 8'h00, 8'h01, "nostb_lk");
    samp(4'd10, 8'h00, 8'h01, "lk10");

    // 300 locked errors with relock in between: count saturates at 255.
    p = 4'd10;
    for (int k = 1; k <= 300; k++) begin
      ecnt = (k > 255) ? 8'hFF : 8'(k);
      v = p + 4'd3;
      samp(v, ecnt, 8'h06, "sat_err");
      for (int j = 1; j <= 4; j++) begin
        nv   = v + 4'(j);
        euio = 8'h02;
        if (j == 4) euio = euio | 8'h01;
        if (nv == 4'd0) euio = euio | 8'h08;
        samp(nv, ecnt, euio, "sat_relock");
      end
      p = v + 4'd4;
    end

    // Clear while locked keeps lock.
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 8'h00, 8'h01, "clr_locked");
    nv   = p + 4'd1;
    euio = (nv == 4'd0) ? 8'h09 : 8'h01;
    samp(nv, 8'h00, euio, "after_clr");
    p = nv;

    // Mid-run reset, then reacquire from IDLE.
    idle(LAT);
    cyc(1'b1, p + 4'd1, 1'b0, 1'b0, 8'h00, 8'h00, "pre_rst");
    do_reset("mid_reset");
    samp(4'd3, 8'h00, 8'h00, "r3");
    samp(4'd4, 8'h00, 8'h00, "r4");
    samp(4'd5, 8'h00, 8'h00, "r5");
    samp(4'd6, 8'h00, 8'h00, "r6");
    samp(4'd7, 8'h00, 8'h01, "r7_lock");

    idle(LAT + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_um_prampal_count_checker.md
# tt_um_prampal_count_checker

Receive-side companion to the team's 4-bit enable-gated counter tile. It samples an external 4-bit count stream on the dedicated inputs and checks that every sampled value is the previous one plus 1, mod 16. It locks after a run of correct steps, and reports loss of lock, wrap events and a saturating error count. It is intended to sit on a second Tiny Tapeout tile, or in a loopback bench, wired pin-to-pin to the counter's uo_out[3:0] and enable.

## Interface
- LOCK_COUNT, default 4: consecutive correct steps required to enter LOCKED; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- ena  in  1  tile power indicator; ignored.
- ui_in  in  8  [3:0] observed count; [4] sample strobe (1 = count valid this cycle); [5] clear error counter and sticky flag; [7:6] unused.
- uo_out  out  8  saturating error count, 0..255.
- uio_in  in  8  unused.
- uio_out  out  8  [0] locked; [1] sticky error; [2] error pulse; [3] wrap pulse; [7:4] = 0.
- uio_oe  out  8  constant 8'h0F.

## Operation
- Sample event: ui_in[4] = 1 at a rising edge, after the optional synchronizer. Cycles with ui_in[4] = 0 change nothing except that the pulses clear.
- Expected value: prev + 1, computed in 4 bits, so 15 is followed by 0.
- State machine has three states: IDLE, TRACK, LOCKED.
  - IDLE: on the first sample, store the value as prev, set match_cnt = 0 and go to TRACK. No check is made.
  - TRACK, correct step: match_cnt + 1. When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - TRACK, wrong step: match_cnt = 0 and stay in TRACK. This is not counted as an error.
  - LOCKED, wrong step: error count + 1 (saturating at 255), sticky = 1, error pulse = 1, match_cnt = 0, go to TRACK.
  - LOCKED, correct step: stay in LOCKED.
- prev is loaded with the sampled value on every sample event, so a wrong value re-seeds the tracking.
- A repeated value (equal to prev) counts as a wrong step.
- Wrap pulse: one cycle when a correct 15 -> 0 step is accepted, in TRACK or LOCKED.
- Clear (ui_in[5] = 1): zeros the error count and sticky flag. It does not affect state, prev or match_cnt.
- Clear and error in the same cycle: clear applies first, then the error is added. Result: count = 1, sticky = 1.
- At error count 255, further errors leave it at 255; sticky and error pulse still assert.
- Reset values: state IDLE, prev 0, match_cnt 0, error count 0, all uo_out = 0, uio_out = 0. uio_oe is 8'h0F at all times.
- Reset mid-operation: the next edge with rst_n = 0 forces the reset values; any in-flight synchronizer contents are discarded (flops cleared).

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Without the synchronizer: a sample at edge N is reflected on the outputs immediately after edge N. Pulses are high for exactly one cycle, from edge N to edge N+1.
- With the synchronizer: add 2 cycles to every input-to-output latency, including clear.
- Lock timing: locked rises after the sample that completes LOCK_COUNT correct steps. With the default LOCK_COUNT = 4 this is the 5th sample after IDLE.
- Unlock timing: locked falls in the same cycle that the error pulse rises.
- Back-to-back samples (strobe held high) are supported at one sample per clock.

## Configuration
- CHECKER_SYNC_EN defined: ui_in[5:0] passes through a 2-flop synchronizer before use, which is safe for asynchronous external pins.
- CHECKER_SYNC_EN undefined: ui_in is used directly, with zero added latency. This mode is for on-die or synchronous loopback only.
- The LOCK_COUNT semantics are identical in both builds.

## Test plan
- Reset, then feed 0,1,2,3,4 with the strobe held high: locked = 1 after the 5th sample; error count = 0.
- Locked, then feed 5,6,9: error pulse for 1 cycle, uo_out = 1, sticky = 1, locked = 0. A further 10,11,12,13 relocks (4 steps from 9).
- Feed 13,14,15,0,1: wrap pulse high exactly one cycle after the 0 sample; no error.
- While locked, strobe a mismatch and assert clear in the same cycle: uo_out = 1, sticky = 1. Clear alone on the next cycle gives uo_out = 0, sticky = 0, locked state unchanged.
- Force 300 locked-mismatch cycles (relocking between them): uo_out stays at 255 and does not wrap.
- Strobe low for 10 cycles with changing ui_in[3:0]: no state or output change. Also pull rst_n low for one edge mid-run: all outputs 0 and state IDLE. With CHECKER_SYNC_EN, all of the above responses are delayed by 2 cycles.
